// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI video timing source: default 640x480@60 raster,
// pattern and FSM encodings, and the TMDS control symbols used by the encoders.
package hdmi_pkg;

    localparam int HDMI_H_ACTIVE = 640;
    localparam int HDMI_H_FP     = 16;
    localparam int HDMI_H_SYNC   = 96;
    localparam int HDMI_H_BP     = 48;
    localparam int HDMI_V_ACTIVE = 480;
    localparam int HDMI_V_FP     = 10;
    localparam int HDMI_V_SYNC   = 2;
    localparam int HDMI_V_BP     = 33;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GREY  = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    // Control-period symbols indexed by CD = {c1, c0}
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Bundle between the timing source and the three TMDS encoder lanes.
interface hdmi_video_timing_if;
    import hdmi_pkg::*;

    logic        en;
    logic [1:0]  pattern_sel;
    logic        pix_stb;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        VDE;
    logic [1:0]  CD;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_start;
    logic        running;
    state_e      dbg_state;

    // pix_stb acts as valid for every pixel output; there is no ready, the sink
    // must accept each pixel, and all pixel outputs stay stable between strobes.
    modport master (
        input  en, pattern_sel,
        output pix_stb, hcount, vcount, VDE, CD, red, green, blue,
               frame_start, running, dbg_state
    );

    modport slave (
        output en, pattern_sel,
        input  pix_stb, hcount, vcount, VDE, CD, red, green, blue,
               frame_start, running, dbg_state
    );

endinterface

// File: rtl/hdmi_pattern_gen.sv
// Combinational test-pattern map from raster position to RGB; blank outside
// the active area. The caller registers the result.
module hdmi_pattern_gen
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = HDMI_H_ACTIVE
) (
    input  logic [11:0] i_h,
    input  logic [7:0]  i_v,
    input  pat_e        i_pat,
    input  logic [7:0]  i_frame_cnt,
    input  logic        i_vde,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue
);

    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [11:0] w_bar;
    logic [2:0]  w_bar_rgb;

    assign w_bar = i_h / 12'(BAR_W);

    // One bit per component, {R,G,B}
    always_comb begin
        w_bar_rgb = 3'b000;
        case (w_bar)
            12'd0:   w_bar_rgb = 3'b111;
            12'd1:   w_bar_rgb = 3'b110;
            12'd2:   w_bar_rgb = 3'b011;
            12'd3:   w_bar_rgb = 3'b010;
            12'd4:   w_bar_rgb = 3'b101;
            12'd5:   w_bar_rgb = 3'b100;
            12'd6:   w_bar_rgb = 3'b001;
            default: w_bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        o_red   = 8'h00;
        o_green = 8'h00;
        o_blue  = 8'h00;
        if (i_vde) begin
            case (i_pat)
                PAT_BARS: begin
                    o_red   = {8{w_bar_rgb[2]}};
                    o_green = {8{w_bar_rgb[1]}};
                    o_blue  = {8{w_bar_rgb[0]}};
                end
                PAT_GRAD: begin
                    o_red   = i_h[7:0];
                    o_green = i_v;
                    o_blue  = i_frame_cnt;
                end
                PAT_CHECK: begin
                    o_red   = {8{~(i_h[5] ^ i_v[5])}};
                    o_green = {8{~(i_h[5] ^ i_v[5])}};
                    o_blue  = {8{~(i_h[5] ^ i_v[5])}};
                end
                default: begin
                    o_red   = 8'h80;
                    o_green = 8'h80;
                    o_blue  = 8'h80;
                end
            endcase
        end
    end

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing source on the TMDS bit clock: divides to a pixel strobe, runs the
// IDLE/RUN/STOP sequencer, and registers position, sync, VDE and RGB together.
module hdmi_video_timing
    import hdmi_pkg::*;
#(
    parameter int CLK_DIV  = 10,
    parameter int H_ACTIVE = HDMI_H_ACTIVE,
    parameter int H_FP     = HDMI_H_FP,
    parameter int H_SYNC   = HDMI_H_SYNC,
    parameter int H_BP     = HDMI_H_BP,
    parameter int V_ACTIVE = HDMI_V_ACTIVE,
    parameter int V_FP     = HDMI_V_FP,
    parameter int V_SYNC   = HDMI_V_SYNC,
    parameter int V_BP     = HDMI_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    hdmi_video_timing_if.master bus
);

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0] CD_IDLE = {~VS_POL, ~HS_POL};

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    state_e           r_state, w_state_nxt;
    logic [11:0]      r_h, r_v, w_h_nxt, w_v_nxt;
    logic             w_load, w_frame_start, w_to_idle;
    pat_e             r_pat, w_pat_nxt;
    logic [7:0]       r_frame_cnt, w_frame_cnt_nxt;
    logic             w_vde, w_hs, w_vs;
    logic [7:0]       w_red, w_green, w_blue;
    logic             r_vde, r_pix_stb, r_frame_start;
    logic [1:0]       r_cd;
    logic [7:0]       r_red, r_green, r_blue;

    assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Sequencer and next raster position; w_load marks an edge that outputs a pixel
    always_comb begin
        w_state_nxt   = r_state;
        w_h_nxt       = r_h;
        w_v_nxt       = r_v;
        w_load        = 1'b0;
        w_frame_start = 1'b0;
        w_to_idle     = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        w_state_nxt   = ST_RUN;
                        w_h_nxt       = '0;
                        w_v_nxt       = '0;
                        w_load        = 1'b1;
                        w_frame_start = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = bus.en ? ST_RUN : ST_STOP;
                    w_load      = 1'b1;
                    if (r_h == 12'(H_TOT - 1)) begin
                        w_h_nxt = '0;
                        if (r_v == 12'(V_TOT - 1)) begin
                            w_v_nxt = '0;
                            if (bus.en) begin
                                w_frame_start = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_load      = 1'b0;
                                w_to_idle   = 1'b1;
                            end
                        end else begin
                            w_v_nxt = r_v + 12'd1;
                        end
                    end else begin
                        w_h_nxt = r_h + 12'd1;
                    end
                end
            endcase
        end
    end

    assign w_pat_nxt       = w_frame_start ? pat_e'(bus.pattern_sel) : r_pat;
    assign w_frame_cnt_nxt = w_frame_start ? (r_frame_cnt + 8'd1) : r_frame_cnt;

    assign w_vde = (w_h_nxt < 12'(H_ACTIVE)) && (w_v_nxt < 12'(V_ACTIVE));
    assign w_hs  = ((w_h_nxt >= 12'(HS_START)) && (w_h_nxt < 12'(HS_END))) ? HS_POL : ~HS_POL;
    assign w_vs  = ((w_v_nxt >= 12'(VS_START)) && (w_v_nxt < 12'(VS_END))) ? VS_POL : ~VS_POL;

    hdmi_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .i_h         (w_h_nxt),
        .i_v         (w_v_nxt[7:0]),
        .i_pat       (w_pat_nxt),
        .i_frame_cnt (w_frame_cnt_nxt),
        .i_vde       (w_vde),
        .o_red       (w_red),
        .o_green     (w_green),
        .o_blue      (w_blue)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_vde         <= 1'b0;
            r_cd          <= CD_IDLE;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_pix_stb     <= 1'b0;
            r_frame_start <= 1'b0;
            r_pat         <= PAT_BARS;
            r_frame_cnt   <= '0;
        end else begin
            r_div_cnt     <= w_tick ? '0 : (r_div_cnt + 1'b1);
            r_pix_stb     <= w_load;
            r_frame_start <= w_frame_start;
            r_pat         <= w_pat_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            if (w_load) begin
                r_h     <= w_h_nxt;
                r_v     <= w_v_nxt;
                r_vde   <= w_vde;
                r_cd    <= {w_vs, w_hs};
                r_red   <= w_red;
                r_green <= w_green;
                r_blue  <= w_blue;
            end else if (w_to_idle) begin
                r_h     <= '0;
                r_v     <= '0;
                r_vde   <= 1'b0;
                r_cd    <= CD_IDLE;
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    assign bus.pix_stb     = r_pix_stb;
    assign bus.hcount      = r_h;
    assign bus.vcount      = r_v;
    assign bus.VDE         = r_vde;
    assign bus.CD          = r_cd;
    assign bus.red         = r_red;
    assign bus.green       = r_green;
    assign bus.blue        = r_blue;
    assign bus.frame_start = r_frame_start;
    assign bus.running     = (r_state != ST_IDLE);
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a shrunken raster: per-cycle reference model
// plus a table of fixed pixel vectors and hand-written enable/reset sequences.
module tb_hdmi_video_timing;
    import hdmi_pkg::*;

    localparam int D          = 3;
    localparam int H_ACTIVE   = 64;
    localparam int H_FP       = 4;
    localparam int H_SYNC     = 8;
    localparam int H_BP       = 4;
    localparam int V_ACTIVE   = 36;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 1;
    localparam int H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLKS = H_TOT * V_TOT * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    hdmi_video_timing_if bus ();

    hdmi_video_timing #(
        .CLK_DIV (D), .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL (1'b0), .VS_POL (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no event within the cycle budget, expected one", name);
    endtask

    // Reference pixel computed directly from the raster rules
    typedef struct packed {
        logic        vde;
        logic [1:0]  cd;
        logic [23:0] rgb;
    } pix_t;

    logic [23:0] bar_color [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic pix_t ref_pixel(input int h, input int v, input int pat, input int fc);
        pix_t p;
        p.vde = (h < H_ACTIVE) && (v < V_ACTIVE);
        p.cd[0] = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
        p.cd[1] = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
        p.rgb = 24'h0;
        if (p.vde) begin
            case (pat)
                0: p.rgb = bar_color[h / (H_ACTIVE / 8)];
                1: p.rgb = 24'((h % 256) * 65536 + (v % 256) * 256 + (fc % 256));
                2: p.rgb = ((((h / 32) + (v / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
                default: p.rgb = 24'h808080;
            endcase
        end
        return p;
    endfunction

    // Input capture at the active edge and cycle bookkeeping
    int         edge_k = 0;
    int         cyc = 0;
    logic       edge_en = 1'b0;
    logic [1:0] edge_sel = 2'd0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) edge_k = 0;
        else        edge_k++;
        edge_en  = bus.en;
        edge_sel = bus.pattern_sel;
    end

    // Reference model state
    bit   m_active = 1'b0;
    bit   fs_chain = 1'b0;
    int   m_h = 0, m_v = 0, m_pat = 0, m_fc = 0, last_fs = 0;
    bit   strobe, fs;
    pix_t ep;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            fs_chain = 1'b0;
            m_fc     = 0;
            check("rst_pix_stb", 32'(bus.pix_stb), 32'd0);
            check("rst_frame_start", 32'(bus.frame_start), 32'd0);
            check("rst_vde", 32'(bus.VDE), 32'd0);
            check("rst_cd", 32'(bus.CD), 32'd3);
            check("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
            check("rst_pos", 32'({bus.hcount, bus.vcount}), 32'd0);
            check("rst_running", 32'(bus.running), 32'd0);
        end else if (edge_k > 0 && (edge_k % D) == 0) begin
            strobe = 1'b1;
            fs     = 1'b0;
            if (!m_active) begin
                strobe = edge_en;
                fs     = edge_en;
            end else if (m_h == H_TOT - 1 && m_v == V_TOT - 1) begin
                strobe = edge_en;
                fs     = edge_en;
                if (!edge_en) begin
                    m_active = 1'b0;
                    fs_chain = 1'b0;
                end
            end
            check("pix_stb", 32'(bus.pix_stb), 32'(strobe));
            check("frame_start", 32'(bus.frame_start), 32'(fs));
            if (strobe) begin
                if (fs) begin
                    if (fs_chain) check("frame_period", 32'(cyc - last_fs), 32'(FRAME_CLKS));
                    fs_chain = 1'b1;
                    last_fs  = cyc;
                    m_active = 1'b1;
                    m_h      = 0;
                    m_v      = 0;
                    m_pat    = int'(edge_sel);
                    m_fc     = (m_fc + 1) % 256;
                end else begin
                    m_h++;
                    if (m_h == H_TOT) begin
                        m_h = 0;
                        m_v = (m_v + 1) % V_TOT;
                    end
                end
                ep = ref_pixel(m_h, m_v, m_pat, m_fc);
                check("hcount", 32'(bus.hcount), 32'(m_h));
                check("vcount", 32'(bus.vcount), 32'(m_v));
                check("vde", 32'(bus.VDE), 32'(ep.vde));
                check("cd", 32'(bus.CD), 32'(ep.cd));
                check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(ep.rgb));
                check("state", 32'(bus.dbg_state), edge_en ? 32'(ST_RUN) : 32'(ST_STOP));
            end else begin
                check("idle_vde", 32'(bus.VDE), 32'd0);
                check("idle_cd", 32'(bus.CD), 32'd3);
                check("idle_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
                check("idle_pos", 32'({bus.hcount, bus.vcount}), 32'd0);
                check("idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
            end
            check("running", 32'(bus.running), 32'(m_active));
        end else begin
            check("stb_off_tick", 32'(bus.pix_stb), 32'd0);
            check("fs_off_tick", 32'(bus.frame_start), 32'd0);
        end
    end

    // Fixed pixel vectors; next_sel is driven right after the entry is checked
    typedef struct {
        int         h;
        int         v;
        logic [1:0] pat;
        logic [23:0] rgb;
        logic       vde;
        logic [1:0] cd;
        logic [1:0] next_sel;
    } vec_t;

    vec_t vecs [20];

    task automatic wait_pos(input int h, input int v, input string name);
        int n;
        n = 0;
        while (!(bus.pix_stb && bus.hcount == 12'(h) && bus.vcount == 12'(v)) && n < 2 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME_CLKS) note_timeout(name);
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 2 * FRAME_CLKS);
        if (!bus.frame_start) note_timeout(name);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        bit   found;
        bit   saw;
        logic [1:0] cur;

        vecs[0]  = '{7,  0,  2'd0, 24'hFFFFFF, 1'b1, 2'b11, 2'd0};
        vecs[1]  = '{8,  0,  2'd0, 24'hFFFF00, 1'b1, 2'b11, 2'd0};
        vecs[2]  = '{16, 0,  2'd0, 24'h00FFFF, 1'b1, 2'b11, 2'd2};
        vecs[3]  = '{24, 0,  2'd0, 24'h00FF00, 1'b1, 2'b11, 2'd2};
        vecs[4]  = '{63, 0,  2'd0, 24'h000000, 1'b1, 2'b11, 2'd2};
        vecs[5]  = '{64, 0,  2'd0, 24'h000000, 1'b0, 2'b11, 2'd2};
        vecs[6]  = '{68, 0,  2'd0, 24'h000000, 1'b0, 2'b10, 2'd2};
        vecs[7]  = '{76, 3,  2'd0, 24'h000000, 1'b0, 2'b11, 2'd2};
        vecs[8]  = '{40, 5,  2'd0, 24'hFF0000, 1'b1, 2'b11, 2'd2};
        vecs[9]  = '{0,  37, 2'd0, 24'h000000, 1'b0, 2'b01, 2'd2};
        vecs[10] = '{70, 38, 2'd0, 24'h000000, 1'b0, 2'b00, 2'd2};
        vecs[11] = '{0,  39, 2'd0, 24'h000000, 1'b0, 2'b11, 2'd2};
        vecs[12] = '{0,  0,  2'd2, 24'hFFFFFF, 1'b1, 2'b11, 2'd2};
        vecs[13] = '{32, 0,  2'd2, 24'h000000, 1'b1, 2'b11, 2'd2};
        vecs[14] = '{0,  32, 2'd2, 24'h000000, 1'b1, 2'b11, 2'd2};
        vecs[15] = '{32, 32, 2'd2, 24'hFFFFFF, 1'b1, 2'b11, 2'd3};
        vecs[16] = '{63, 35, 2'd2, 24'hFFFFFF, 1'b1, 2'b11, 2'd3};
        vecs[17] = '{5,  5,  2'd3, 24'h808080, 1'b1, 2'b11, 2'd3};
        vecs[18] = '{64, 5,  2'd3, 24'h000000, 1'b0, 2'b11, 2'd3};
        vecs[19] = '{10, 36, 2'd3, 24'h000000, 1'b0, 2'b11, 2'd1};

        bus.en = 1'b0;
        bus.pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle with en low: no strobes, outputs at reset values
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.pix_stb) saw = 1'b1;
        end
        check("idle_no_stb", 32'(saw), 32'd0);
        check("idle_running", 32'(bus.running), 32'd0);
        check("idle_cd_50", 32'(bus.CD), 32'd3);

        // Start latency from reset release and strobe spacing
        #1 rst_n = 1'b0;
        bus.en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(posedge clk);
            n++;
            #1 found = bus.pix_stb;
        end
        if (!found) note_timeout("first_stb");
        else begin
            check("first_stb_latency", 32'(n), 32'(D));
            check("first_pos", 32'({bus.hcount, bus.vcount}), 32'd0);
            check("first_fs", 32'(bus.frame_start), 32'd1);
            check("first_vde", 32'(bus.VDE), 32'd1);
            check("first_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFFFFFF);
        end
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(posedge clk);
            n++;
            #1 found = bus.pix_stb;
        end
        if (!found) note_timeout("second_stb");
        else check("stb_spacing", 32'(n), 32'(D));

        // Table vectors; pattern changes land only at the next frame start
        cur = 2'd0;
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].pat != cur) begin
                wait_fs("vec_frame_start");
                cur = vecs[i].pat;
            end
            wait_pos(vecs[i].h, vecs[i].v, "vec_position");
            check($sformatf("vec%0d_rgb", i), 32'({bus.red, bus.green, bus.blue}), 32'(vecs[i].rgb));
            check($sformatf("vec%0d_vde", i), 32'(bus.VDE), 32'(vecs[i].vde));
            check($sformatf("vec%0d_cd", i), 32'(bus.CD), 32'(vecs[i].cd));
            #1 bus.pattern_sel = vecs[i].next_sel;
        end

        // Random enable and pattern traffic against the reference model
        for (int c = 0; c < 2 * FRAME_CLKS + FRAME_CLKS / 2; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 1999) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 399) == 0) bus.pattern_sel = 2'($urandom_range(0, 3));
        end
        bus.en = 1'b1;

        // Enable dropped mid-frame: frame completes, then IDLE
        wait_pos(0, 10, "drop_line10");
        #1 bus.en = 1'b0;
        wait_pos(H_TOT - 1, V_TOT - 1, "drop_last_pixel");
        check("stop_running", 32'(bus.running), 32'd1);
        check("stop_state", 32'(bus.dbg_state), 32'(ST_STOP));
        repeat (D) @(negedge clk);
        check("drop_running", 32'(bus.running), 32'd0);
        check("drop_vde", 32'(bus.VDE), 32'd0);
        check("drop_cd", 32'(bus.CD), 32'd3);
        check("drop_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
        check("drop_pos", 32'({bus.hcount, bus.vcount}), 32'd0);
        repeat (3 * D) @(negedge clk);

        // Asynchronous reset mid-line, then restart from (0,0)
        #1 bus.en = 1'b1;
        wait_pos(20, 1, "rst_midline_pos");
        #1 rst_n = 1'b0;
        #1;
        check("async_pos", 32'({bus.hcount, bus.vcount}), 32'd0);
        check("async_vde", 32'(bus.VDE), 32'd0);
        check("async_cd", 32'(bus.CD), 32'd3);
        check("async_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
        check("async_running", 32'(bus.running), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_pos(0, 0, "restart_origin");
        check("restart_fs", 32'(bus.frame_start), 32'd1);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
